// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin two-requester AXI4 read arbiter with a single burst outstanding.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic              M_AXI_RVALID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  output logic              M_AXI_RREADY,
  output logic              gnt_owner,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   sel0, sel1;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (s0_arvalid | s1_arvalid) begin
        state_d = ADDR;
        // on a tie the requester not served last wins
        owner_d = (s0_arvalid & s1_arvalid) ? ~last_q : s1_arvalid;
      end
      ADDR: if (M_AXI_ARREADY) state_d = DATA;
      DATA: if (M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST) begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sel0          = (state_q == DATA) & ~owner_q;
    sel1          = (state_q == DATA) & owner_q;
    M_AXI_ARVALID = state_q == ADDR;
    M_AXI_ARADDR  = owner_q ? s1_araddr : s0_araddr;
    M_AXI_ARLEN   = owner_q ? s1_arlen : s0_arlen;
    M_AXI_ARSIZE  = 3'b010;
    M_AXI_ARBURST = 2'b01;
    s0_arready    = M_AXI_ARVALID & ~owner_q & M_AXI_ARREADY;
    s1_arready    = M_AXI_ARVALID & owner_q & M_AXI_ARREADY;
    M_AXI_RREADY  = (sel0 & s0_rready) | (sel1 & s1_rready);
    s0_rvalid     = sel0 & M_AXI_RVALID;
    s1_rvalid     = sel1 & M_AXI_RVALID;
    s0_rdata      = sel0 ? M_AXI_RDATA : '0;
    s1_rdata      = sel1 ? M_AXI_RDATA : '0;
    s0_rresp      = sel0 ? M_AXI_RRESP : 2'b00;
    s1_rresp      = sel1 ? M_AXI_RRESP : 2'b00;
    s0_rlast      = sel0 & M_AXI_RLAST;
    s1_rlast      = sel1 & M_AXI_RLAST;
    gnt_owner     = owner_q;
    busy          = state_q != IDLE;
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic aclk = 1'b0;
  logic aresetn;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s0_araddr, s1_araddr, M_AXI_ARADDR;
  logic [7:0] s0_arlen, s1_arlen, M_AXI_ARLEN;
  logic [DW-1:0] s0_rdata, s1_rdata, M_AXI_RDATA;
  logic [1:0] s0_rresp, s1_rresp, M_AXI_RRESP, M_AXI_ARBURST;
  logic [2:0] M_AXI_ARSIZE;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
  logic gnt_owner, busy;
  int n_tot = 0;
  int n_bad = 0;
  logic rq_pend [2];
  logic [AW-1:0] rq_addr [2];
  logic [7:0] rq_len [2];

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY), .gnt_owner(gnt_owner), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_in;
    s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_rready = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 0;
    rq_pend[0] = 0; rq_pend[1] = 0;
  endtask

  task automatic do_reset;
    aresetn = 0;
    clr_in();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
  endtask

  task automatic test_reset;
    aresetn = 0;
    clr_in();
    s0_arvalid = 1; s1_arvalid = 1; M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RLAST = 1;
    s0_rready = 1; s1_rready = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, s0_arready, s1_arready, M_AXI_RREADY, s0_rvalid, s1_rvalid, busy, gnt_owner} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b exp 00000000",
        {M_AXI_ARVALID, s0_arready, s1_arready, M_AXI_RREADY, s0_rvalid, s1_rvalid, busy, gnt_owner});
    end
    step();
    aresetn = 1;
    M_AXI_RVALID = 0;
    @(negedge aclk);
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: busy got %b exp 0", busy); end
    step();
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, gnt_owner} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_first_tie: arvalid/owner got %b exp 10", {M_AXI_ARVALID, gnt_owner});
    end
  endtask

  task automatic test_single;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h100; s0_arlen = 8'd3; M_AXI_ARREADY = 1;
    @(negedge aclk);
    n_tot++;
    if (M_AXI_ARVALID !== 1'b0) begin n_bad++; $display("FAIL single_idle_arvalid: got %b exp 0", M_AXI_ARVALID); end
    step();
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, s0_arready, s1_arready, busy, gnt_owner} !== 5'b11010) begin
      n_bad++;
      $display("FAIL single_addr_ctl: got %b exp 11010", {M_AXI_ARVALID, s0_arready, s1_arready, busy, gnt_owner});
    end
    n_tot++;
    if ({M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} !== {32'h100, 8'd3, 3'b010, 2'b01}) begin
      n_bad++;
      $display("FAIL single_addr_fields: got %h/%h/%b/%b exp 100/03/010/01", M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST);
    end
    step();
    s0_arvalid = 0; s0_rready = 1; M_AXI_RVALID = 1; M_AXI_RRESP = 0;
    for (int b = 0; b < 4; b++) begin
      M_AXI_RDATA = 32'(32'hA0 + b);
      M_AXI_RLAST = (b == 3);
      @(negedge aclk);
      n_tot++;
      if ({s0_rvalid, s0_rlast, s1_rvalid, M_AXI_RREADY, M_AXI_ARVALID} !== {1'b1, (b == 3), 1'b0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL single_beat%0d_ctl: got %b exp %b", b,
          {s0_rvalid, s0_rlast, s1_rvalid, M_AXI_RREADY, M_AXI_ARVALID}, {1'b1, (b == 3), 1'b0, 1'b1, 1'b0});
      end
      n_tot++;
      if ({s0_rdata, s1_rdata} !== {32'(32'hA0 + b), 32'd0}) begin
        n_bad++;
        $display("FAIL single_beat%0d_data: got %h/%h exp %h/0", b, s0_rdata, s1_rdata, 32'(32'hA0 + b));
      end
      step();
    end
    M_AXI_RVALID = 0;
    @(negedge aclk);
    n_tot++;
    if ({busy, M_AXI_RREADY} !== 2'b00) begin n_bad++; $display("FAIL single_done: busy/rready got %b exp 00", {busy, M_AXI_RREADY}); end
  endtask

  task automatic test_round_robin;
    logic e;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h1000; s0_arlen = 0; s0_rready = 1;
    s1_arvalid = 1; s1_araddr = 32'h2000; s1_arlen = 0; s1_rready = 1;
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RDATA = 32'h55;
    for (int k = 0; k < 4; k++) begin
      e = k[0];
      step();
      @(negedge aclk);
      n_tot++;
      if ({M_AXI_ARVALID, gnt_owner, M_AXI_ARADDR} !== {1'b1, e, (e ? 32'h2000 : 32'h1000)}) begin
        n_bad++;
        $display("FAIL rr_grant%0d: arvalid/owner/addr got %b/%b/%h exp 1/%b/%h", k, M_AXI_ARVALID, gnt_owner, M_AXI_ARADDR, e, (e ? 32'h2000 : 32'h1000));
      end
      step();
      @(negedge aclk);
      n_tot++;
      if ({s0_rvalid, s1_rvalid} !== {~e, e}) begin
        n_bad++;
        $display("FAIL rr_route%0d: rvalid0/1 got %b exp %b", k, {s0_rvalid, s1_rvalid}, {~e, e});
      end
      step();
      @(negedge aclk);
      n_tot++;
      if ({busy, s0_rvalid, s1_rvalid} !== 3'b000) begin
        n_bad++;
        $display("FAIL rr_idle%0d: busy/rvalid got %b exp 000", k, {busy, s0_rvalid, s1_rvalid});
      end
    end
  endtask

  task automatic test_ar_stall;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h400; s0_arlen = 1;
    step();
    s1_arvalid = 1; s1_araddr = 32'h800; s1_arlen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      n_tot++;
      if ({M_AXI_ARVALID, busy, s0_arready, s1_arready, M_AXI_ARADDR} !== {4'b1100, 32'h400}) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: ctl/addr got %b/%h exp 1100/400", i, {M_AXI_ARVALID, busy, s0_arready, s1_arready}, M_AXI_ARADDR);
      end
      step();
    end
    M_AXI_ARREADY = 1;
    @(negedge aclk);
    n_tot++;
    if ({s0_arready, s1_arready} !== 2'b10) begin n_bad++; $display("FAIL stall_accept: arready0/1 got %b exp 10", {s0_arready, s1_arready}); end
    step();
    s0_arvalid = 0; s0_rready = 1; M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RLAST = 0;
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, busy} !== 2'b01) begin n_bad++; $display("FAIL stall_data: arvalid/busy got %b exp 01", {M_AXI_ARVALID, busy}); end
    step();
    M_AXI_RLAST = 1;
    step();
    M_AXI_RVALID = 0; M_AXI_ARREADY = 1;
    @(negedge aclk);
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_done: busy got %b exp 0", busy); end
    step();
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, gnt_owner, M_AXI_ARADDR} !== {2'b11, 32'h800}) begin
      n_bad++;
      $display("FAIL stall_pending_s1: arvalid/owner/addr got %b/%b/%h exp 1/1/800", M_AXI_ARVALID, gnt_owner, M_AXI_ARADDR);
    end
  endtask

  task automatic test_backpressure;
    int got;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h500; s0_arlen = 3; M_AXI_ARREADY = 1;
    step();
    step();
    s0_arvalid = 0; M_AXI_RVALID = 1;
    got = 0;
    for (int c = 0; c < 5; c++) begin
      s0_rready = (c != 1);
      M_AXI_RDATA = 32'(32'hB0 + got);
      M_AXI_RLAST = (got == 3);
      @(negedge aclk);
      n_tot++;
      if (M_AXI_RREADY !== (c != 1)) begin n_bad++; $display("FAIL bp_rready%0d: got %b exp %b", c, M_AXI_RREADY, (c != 1)); end
      if (s0_rvalid && s0_rready) begin
        n_tot++;
        if ({s0_rdata, s0_rlast} !== {32'(32'hB0 + got), (got == 3)}) begin
          n_bad++;
          $display("FAIL bp_beat%0d: data/last got %h/%b exp %h/%b", got, s0_rdata, s0_rlast, 32'(32'hB0 + got), (got == 3));
        end
        got++;
      end
      step();
    end
    M_AXI_RVALID = 0;
    @(negedge aclk);
    n_tot++;
    if ({got == 4, busy} !== 2'b10) begin n_bad++; $display("FAIL bp_complete: beats got %0d busy %b exp 4 beats busy 0", got, busy); end
  endtask

  task automatic test_error;
    do_reset();
    s1_arvalid = 1; s1_araddr = 32'h600; s1_arlen = 1; M_AXI_ARREADY = 1;
    step();
    step();
    s1_arvalid = 0; s1_rready = 1; M_AXI_RVALID = 1; M_AXI_RRESP = 2'b10; M_AXI_RLAST = 0; M_AXI_RDATA = 32'hE0;
    @(negedge aclk);
    n_tot++;
    if ({s1_rvalid, s1_rresp, s1_rlast, s0_rvalid, s1_rdata} !== {5'b1_10_0_0, 32'hE0}) begin
      n_bad++;
      $display("FAIL err_beat0: v/resp/last/v0/data got %b/%b/%b/%b/%h exp 1/10/0/0/e0", s1_rvalid, s1_rresp, s1_rlast, s0_rvalid, s1_rdata);
    end
    step();
    M_AXI_RRESP = 0; M_AXI_RLAST = 1; M_AXI_RDATA = 32'hE1;
    @(negedge aclk);
    n_tot++;
    if ({busy, s1_rvalid, s1_rresp, s1_rlast} !== 5'b11001) begin
      n_bad++;
      $display("FAIL err_beat1: busy/v/resp/last got %b exp 11001", {busy, s1_rvalid, s1_rresp, s1_rlast});
    end
    step();
    M_AXI_RVALID = 0;
    @(negedge aclk);
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL err_done: busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h200; s0_arlen = 3; M_AXI_ARREADY = 1;
    step();
    step();
    s0_arvalid = 0; s0_rready = 1; M_AXI_RVALID = 1; M_AXI_RLAST = 0; M_AXI_RDATA = 32'hC0;
    s1_arvalid = 1; s1_araddr = 32'h300; s1_arlen = 0;
    step();
    M_AXI_RDATA = 32'hC1;
    aresetn = 0;
    @(negedge aclk);
    n_tot++;
    if ({busy, M_AXI_ARVALID, M_AXI_RREADY, s0_rvalid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_abort: busy/arvalid/rready/rvalid got %b exp 0000", {busy, M_AXI_ARVALID, M_AXI_RREADY, s0_rvalid});
    end
    step();
    M_AXI_RVALID = 0;
    aresetn = 1;
    @(negedge aclk);
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: busy got %b exp 0", busy); end
    step();
    @(negedge aclk);
    n_tot++;
    if ({M_AXI_ARVALID, gnt_owner, s1_arready, M_AXI_ARADDR} !== {3'b111, 32'h300}) begin
      n_bad++;
      $display("FAIL midrst_regrant: arvalid/owner/arready/addr got %b/%b/%b/%h exp 1/1/1/300", M_AXI_ARVALID, gnt_owner, s1_arready, M_AXI_ARADDR);
    end
  endtask

  // Model view: phase 0 waiting, 1 address offered, 2 beats flowing; burst ends after len+1 accepted beats.
  task automatic test_random;
    int ph, left;
    logic mo, ml, d0, d1, sl_act;
    logic [7:0] sl_beat, sl_len;
    logic [13:0] ex, ac;
    do_reset();
    ph = 0; left = 0; mo = 0; ml = 1; sl_act = 0; sl_beat = 0; sl_len = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 2; i++)
        if (!rq_pend[i] && $urandom_range(0, 3) == 0) begin
          rq_pend[i] = 1;
          rq_addr[i] = ($urandom & 32'h7fff_fff0) | (i == 1 ? 32'h8000_0000 : 32'h0);
          rq_len[i] = 8'($urandom_range(0, 3));
        end
      s0_arvalid = rq_pend[0]; s0_araddr = rq_addr[0]; s0_arlen = rq_len[0];
      s1_arvalid = rq_pend[1]; s1_araddr = rq_addr[1]; s1_arlen = rq_len[1];
      s0_rready = ($urandom_range(0, 3) != 0);
      s1_rready = ($urandom_range(0, 3) != 0);
      M_AXI_ARREADY = ($urandom_range(0, 2) != 0);
      M_AXI_RDATA = $urandom;
      M_AXI_RRESP = 2'($urandom_range(0, 3));
      M_AXI_RVALID = sl_act ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      M_AXI_RLAST = sl_act ? (sl_beat == sl_len) : 1'($urandom_range(0, 1));
      @(negedge aclk);
      d0 = (ph == 2) && !mo;
      d1 = (ph == 2) && mo;
      ex = {ph == 1, ph == 1 && !mo && M_AXI_ARREADY, ph == 1 && mo && M_AXI_ARREADY, ph != 0, mo,
            ph == 2 && (mo ? s1_rready : s0_rready), d0 && M_AXI_RVALID, d1 && M_AXI_RVALID,
            d0 && M_AXI_RLAST, d1 && M_AXI_RLAST, (d0 ? M_AXI_RRESP : 2'b00), (d1 ? M_AXI_RRESP : 2'b00)};
      ac = {M_AXI_ARVALID, s0_arready, s1_arready, busy, gnt_owner, M_AXI_RREADY, s0_rvalid, s1_rvalid,
            s0_rlast, s1_rlast, s0_rresp, s1_rresp};
      n_tot++;
      if (ac !== ex) begin n_bad++; $display("FAIL rand_ctl cyc %0d: got %b exp %b", cyc, ac, ex); end
      n_tot++;
      if ({s0_rdata, s1_rdata} !== {(d0 ? M_AXI_RDATA : 32'd0), (d1 ? M_AXI_RDATA : 32'd0)}) begin
        n_bad++;
        $display("FAIL rand_data cyc %0d: got %h/%h exp %h/%h", cyc, s0_rdata, s1_rdata, (d0 ? M_AXI_RDATA : 32'd0), (d1 ? M_AXI_RDATA : 32'd0));
      end
      if (ph == 1) begin
        n_tot++;
        if ({M_AXI_ARADDR, M_AXI_ARLEN} !== {rq_addr[mo], rq_len[mo]}) begin
          n_bad++;
          $display("FAIL rand_ar cyc %0d: got %h/%h exp %h/%h", cyc, M_AXI_ARADDR, M_AXI_ARLEN, rq_addr[mo], rq_len[mo]);
        end
      end
      if (ph == 0) begin
        if (rq_pend[0] || rq_pend[1]) begin
          mo = (rq_pend[0] && rq_pend[1]) ? ~ml : rq_pend[1];
          ph = 1;
        end
      end else if (ph == 1) begin
        if (M_AXI_ARREADY) begin ph = 2; left = int'(rq_len[mo]) + 1; end
      end else if (M_AXI_RVALID && (mo ? s1_rready : s0_rready)) begin
        left--;
        if (left == 0) begin ph = 0; ml = mo; end
      end
      if (s0_arvalid && s0_arready) rq_pend[0] = 0;
      if (s1_arvalid && s1_arready) rq_pend[1] = 0;
      if (!sl_act && M_AXI_ARVALID && M_AXI_ARREADY) begin
        sl_act = 1; sl_beat = 0; sl_len = M_AXI_ARLEN;
      end else if (sl_act && M_AXI_RVALID && M_AXI_RREADY) begin
        if (sl_beat == sl_len) sl_act = 0;
        else sl_beat++;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of every read address.
REQ-002 SHALL have parameter DATA_W, default 32, width of every read data bus.
REQ-003 SHALL have aclk  input  1  the single clock; all logic rises on posedge aclk.
REQ-004 SHALL have aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have s{0,1}_arvalid  input  1  read request from requester 0 (I-cache) or 1 (D-cache).
REQ-006 SHALL have s{0,1}_arready  output  1  address accepted for that requester.
REQ-007 SHALL have s{0,1}_araddr  input  ADDR_W  burst start address.
REQ-008 SHALL have s{0,1}_arlen  input  8  AXI4 burst length minus one.
REQ-009 SHALL have s{0,1}_rvalid  output  1  read beat valid to that requester.
REQ-010 SHALL have s{0,1}_rready  input  1  requester accepts beat.
REQ-011 SHALL have s{0,1}_rdata / s{0,1}_rresp / s{0,1}_rlast  output  DATA_W / 2 / 1  routed beat payload.
REQ-012 SHALL have M_AXI_ARADDR / M_AXI_ARLEN  output  ADDR_W / 8  forwarded address and length.
REQ-013 SHALL have M_AXI_ARSIZE / M_AXI_ARBURST  output  3 / 2  constant 3'b010 and 2'b01 (INCR).
REQ-014 SHALL have M_AXI_ARVALID output 1 and M_AXI_ARREADY input 1, AR handshake to shared slave.
REQ-015 SHALL have M_AXI_RVALID / M_AXI_RDATA / M_AXI_RRESP / M_AXI_RLAST  input  1 / DATA_W / 2 / 1  R channel from slave.
REQ-016 SHALL have M_AXI_RREADY  output  1  R channel ready to slave.
REQ-017 SHALL have gnt_owner output 1 (current owner index) and busy output 1 (state != IDLE).

Function
REQ-018 SHALL implement a 3-state FSM: IDLE, ADDR, DATA; exactly one burst outstanding.
REQ-019 IDLE: if any s*_arvalid, SHALL latch owner and go to ADDR next cycle; else stay IDLE.
REQ-020 Arbitration SHALL be round-robin: with both requesting, grant the one not served last; single requester always wins; after reset, last-served = 1 so requester 0 wins first tie.
REQ-021 ADDR: M_AXI_ARVALID=1, ARADDR/ARLEN driven from owner's inputs; owner s_arready = M_AXI_ARREADY; non-owner s_arready=0.
REQ-022 ADDR: on M_AXI_ARVALID&M_AXI_ARREADY SHALL go to DATA; ARVALID SHALL stay high until then (no withdrawal).
REQ-023 DATA: owner s_rvalid/rdata/rresp/rlast = M_AXI_R*; M_AXI_RREADY = owner s_rready; non-owner s_rvalid=0, rdata=0, rresp=0, rlast=0.
REQ-024 DATA: on M_AXI_RVALID&M_AXI_RREADY&M_AXI_RLAST SHALL go to IDLE and record owner as last-served; earliest new ARVALID is two cycles after the last beat.
REQ-025 Non-last beats and RRESP errors (SLVERR/DECERR) SHALL be forwarded unchanged; error SHALL NOT end the burst early.
REQ-026 Outside DATA, M_AXI_RREADY SHALL be 0 and every s*_rvalid SHALL be 0; outside ADDR, M_AXI_ARVALID and every s*_arready SHALL be 0.
REQ-027 The non-owner's request SHALL be held pending (not dropped) and served after the current burst.
REQ-028 Latency: request in IDLE to M_AXI_ARVALID = 1 cycle; R path SHALL be combinational pass-through (zero added latency).

Reset
REQ-029 While aresetn=0: state=IDLE, owner=0, last-served=1, all ARVALID/RREADY/s*_arready/s*_rvalid/busy=0.
REQ-030 Reset asserted mid-ADDR or mid-DATA SHALL abort immediately to IDLE; no burst resumes after release.
REQ-031 First arbitration SHALL occur on the first rising edge after aresetn deasserts.

Verification
REQ-032 Only s0 requests addr 0x100, arlen=3; slave ARREADY=1 -> ARVALID one cycle later with ARADDR=0x100, ARLEN=3; four beats to s0, s1_rvalid stays 0.
REQ-033 s0 and s1 request same cycle after reset -> s0 served first, s1 next; both again simultaneously -> s0 (last-served=1, then s0 served... order alternates s0,s1,s0,s1).
REQ-034 Slave holds ARREADY=0 for 5 cycles -> ARVALID and ARADDR stable all 5 cycles, FSM stays ADDR.
REQ-035 Owner drops s_rready on beat 2 of 4 -> M_AXI_RREADY=0 that cycle, no beat lost, rlast only on beat 4.
REQ-036 Beat 1 returns RRESP=2'b10 -> forwarded to owner, burst completes with rlast, FSM returns IDLE.
REQ-037 aresetn pulled low during DATA beat 2 -> next cycle ARVALID=0, RREADY=0, busy=0; after release, s1 pending request granted with fresh ARVALID.
